// File: rtl/keypad_pkg.sv
// Shared types, sizes and key-code map for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KP_IDX_W = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    typedef struct packed {
        logic [KP_IDX_W-1:0] row;
        logic [KP_IDX_W-1:0] col;
    } kp_key_t;

    // Rows top-to-bottom, columns left-to-right.
    function automatic logic [3:0] kp_map(input logic [KP_IDX_W-1:0] row,
                                          input logic [KP_IDX_W-1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; idles at all-ones.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with per-dwell debounce of press and release.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd1000,
    parameter logic [3:0]  DEB_COUNT = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] scan_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    logic [3:0]  row_s;
    logic [15:0] div_q, div_d;
    kp_state_t   state_q, state_d;
    logic [1:0]  col_q, col_d;
    kp_key_t     cand_q, cand_d;
    logic [3:0]  deb_q, deb_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic [3:0]  coln_q, coln_d;

    logic        tick;
    logic        samp_none;
    logic        samp_ok;
    logic [1:0]  samp_row;
    logic [3:0]  deb_inc;
    logic        accept;

    sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n),
        .q_o   (row_s)
    );

    assign tick      = (div_q == SCAN_DIV - 16'd1);
    assign samp_none = &row_s;
    assign deb_inc   = (deb_q == 4'hF) ? deb_q : deb_q + 4'd1;

    // Only a single low row is a usable sample; anything else is ghosting.
    always_comb begin
        samp_ok  = 1'b0;
        samp_row = 2'd0;
        case (row_s)
            4'b1110: begin samp_ok = 1'b1; samp_row = 2'd0; end
            4'b1101: begin samp_ok = 1'b1; samp_row = 2'd1; end
            4'b1011: begin samp_ok = 1'b1; samp_row = 2'd2; end
            4'b0111: begin samp_ok = 1'b1; samp_row = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        div_d   = tick ? 16'd0 : div_q + 16'd1;
        state_d = state_q;
        col_d   = col_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (samp_ok) begin
                        cand_d.row = samp_row;
                        cand_d.col = col_q;
                        deb_d      = 4'd1;
                        if (DEB_COUNT <= 4'd1) accept = 1'b1;
                        else                   state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (samp_ok && (samp_row == cand_q.row)) begin
                        deb_d = deb_inc;
                        if (deb_inc >= DEB_COUNT) accept = 1'b1;
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    deb_d = samp_none ? deb_inc : 4'd0;
                    if (samp_none && (deb_inc >= DEB_COUNT)) begin
                        state_d = SCAN;
                        held_d  = 1'b0;
                        col_d   = col_q + 2'd1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        // Release counting restarts from zero once the key is accepted.
        if (accept) begin
            state_d = HELD;
            deb_d   = 4'd0;
            code_d  = kp_map(cand_d.row, cand_d.col);
            valid_d = 1'b1;
            held_d  = 1'b1;
        end

        coln_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= 16'd0;
            state_q <= SCAN;
            col_q   <= 2'd0;
            cand_q  <= '0;
            deb_q   <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            coln_q  <= 4'b1110;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            coln_q  <= coln_d;
        end
    end

    assign col_n     = coln_q;
    assign scan_col  = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan against a cycle-level keypad reference.
module tb_keypad_scan;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_COUNT = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [1:0] scan_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scan #(.SCAN_DIV(16'd4), .DEB_COUNT(4'd3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .scan_col  (scan_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    bit mon_en  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: physical key map, and a tick-level description of scan/debounce/hold.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2;
    logic [3:0] m_hist0 = 4'hF, m_hist1 = 4'hF;
    int m_div = 0, m_col = 0, m_mode = 0, m_streak = 0, m_cand = 0;
    logic [3:0] m_code = 4'h0;
    bit m_valid = 0, m_held = 0;

    always @(posedge clk) begin
        logic [3:0] rs;
        int zeros, zrow;
        bit acc;
        if (!rst_n) begin
            m_hist0 = 4'hF; m_hist1 = 4'hF;
            m_div = 0; m_col = 0; m_mode = M_SCAN; m_streak = 0; m_cand = 0;
            m_code = 4'h0; m_valid = 0; m_held = 0;
        end else begin
            rs = m_hist1;
            m_hist1 = m_hist0;
            m_hist0 = row_n;
            m_valid = 0;
            acc = 0;
            zeros = 0; zrow = 0;
            for (int r = 0; r < 4; r++) if (!rs[r]) begin zeros++; zrow = r; end
            if (m_div == SCAN_DIV - 1) begin
                if (m_mode == M_SCAN) begin
                    if (zeros == 1) begin
                        m_cand = zrow; m_streak = 1;
                        if (m_streak >= DEB_COUNT) acc = 1; else m_mode = M_DEB;
                    end else m_col = (m_col + 1) % 4;
                end else if (m_mode == M_DEB) begin
                    if (zeros == 1 && zrow == m_cand) begin
                        m_streak++;
                        if (m_streak >= DEB_COUNT) acc = 1;
                    end else begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    m_streak = (rs == 4'hF) ? m_streak + 1 : 0;
                    if (m_streak >= DEB_COUNT) begin
                        m_mode = M_SCAN; m_held = 0; m_col = (m_col + 1) % 4;
                    end
                end
                if (acc) begin
                    m_code = keymap[m_cand * 4 + m_col];
                    m_valid = 1; m_held = 1; m_mode = M_HELD; m_streak = 0;
                end
            end
            m_div = (m_div + 1) % SCAN_DIV;
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_col;
        if (key_valid) pulses++;
        if (mon_en) begin
            exp_col = ~(4'b0001 << m_col);
            check("col_n", col_n, exp_col);
            check("scan_col", scan_col, m_col);
            check("key_code", key_code, m_code);
            check("key_valid", key_valid, m_valid);
            check("key_held", key_held, m_held);
        end
    end

    // Keypad: a pressed key pulls its row low while its column is driven.
    logic [15:0] press = 16'h0;
    bit          ovr_en = 0;
    logic [3:0]  ovr_val = 4'hF;

    function automatic logic [3:0] rows_for(input logic [3:0] cn, input logic [15:0] pm);
        logic [3:0] rv;
        rv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pm[r*4+c] && !cn[c]) rv[r] = 1'b0;
        return rv;
    endfunction

    task automatic apply();
        row_n = ovr_en ? ovr_val : rows_for(col_n, press);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            apply();
        end
    endtask

    task automatic wait_held(input string tag);
        for (int i = 0; i < 200 && !key_held; i++) step(1);
        check(tag, key_held, 1);
    endtask

    task automatic align_tick(input string tag);
        for (int i = 0; i < SCAN_DIV + 1; i++) begin
            step(1);
            if (m_div == 0) break;
        end
        check(tag, m_div, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_col_n"}, col_n, 4'b1110);
        check({tag, "_scan_col"}, scan_col, 0);
        check({tag, "_code"}, key_code, 0);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_held"}, key_held, 0);
    endtask

    initial begin
        int c0, sel, dur;
        rst_n = 1'b0;
        row_n = 4'hF;
        step(3);
        check_reset_outs("rst");
        rst_n = 1'b1;
        mon_en = 1;

        // Idle scan: four-cycle dwell per column.
        pulses = 0;
        step(3);
        check("idle_c0", col_n, 4'b1110);
        step(1);
        check("idle_c1", col_n, 4'b1101);
        step(4);
        check("idle_c2", col_n, 4'b1011);
        step(4);
        check("idle_c3", col_n, 4'b0111);
        step(4);
        check("idle_wrap", col_n, 4'b1110);
        check("idle_pulses", pulses, 0);

        // Key at row1/col2.
        pulses = 0;
        press = 16'h1 << 6;
        wait_held("t2_wait");
        step(20);
        check("t2_pulses", pulses, 1);
        check("t2_code", key_code, 4'h6);
        check("t2_col_n", col_n, 4'b1011);
        check("t2_scan_col", scan_col, 2);
        press = 16'h0;
        step(30);
        check("t2_release", key_held, 0);

        // Short two-tick bounce on col3 is rejected.
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (scan_col == 2'd3 && m_div == 0) break;
        end
        check("t3_align", scan_col, 3);
        pulses = 0;
        ovr_en = 1; ovr_val = 4'b1110; apply();
        step(8);
        ovr_val = 4'hF; apply();
        step(4);
        check("t3_col", scan_col, 0);
        check("t3_pulses", pulses, 0);
        check("t3_held", key_held, 0);
        ovr_en = 0; apply();

        // Release glitch while held: 2 high, 1 low, 3 high.
        pulses = 0;
        press = 16'h1 << 9;
        wait_held("t4_wait");
        step(8);
        align_tick("t4_align");
        press = 16'h0; apply(); step(8);
        press = 16'h1 << 9; apply(); step(4);
        press = 16'h0; apply(); step(8);
        check("t4_still_held", key_held, 1);
        step(4);
        check("t4_released", key_held, 0);
        check("t4_pulses", pulses, 1);
        check("t4_code", key_code, 4'h8);

        // Two rows low is ghosting: no capture, column keeps moving.
        pulses = 0;
        ovr_en = 1; ovr_val = 4'b1100; apply();
        align_tick("t5_align");
        step(4);
        c0 = scan_col;
        step(4);
        check("t5_advance", scan_col, (c0 + 1) % 4);
        step(24);
        check("t5_pulses", pulses, 0);
        check("t5_held", key_held, 0);
        ovr_en = 0; apply();

        // Reset in the middle of debounce.
        press = 16'h1;
        for (int i = 0; i < 100 && m_mode != M_DEB; i++) step(1);
        check("t6_deb", m_mode, M_DEB);
        rst_n = 1'b0; press = 16'h0; apply();
        pulses = 0;
        step(1);
        check_reset_outs("t6");
        rst_n = 1'b1;
        step(20);
        check("t6_pulses", pulses, 0);

        // Random keypad activity, compared cycle by cycle with the reference.
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 19);
            dur = $urandom_range(4, 80);
            ovr_en = 0;
            if (sel < 4)       press = 16'h0;
            else if (sel < 13) press = 16'h1 << $urandom_range(0, 15);
            else if (sel < 17) press = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            else if (sel < 19) begin ovr_en = 1; ovr_val = 4'($urandom_range(0, 15)); end
            else begin
                rst_n = 1'b0; apply(); step(1); rst_n = 1'b1;
            end
            apply();
            step(dur);
        end
        press = 16'h0; ovr_en = 0; apply();
        step(40);
        check("final_idle_held", key_held, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-scanning front end for the 4x4 hex keypad. It drives one column line low at a time, synchronises and debounces the active-low row returns, and emits a 4-bit hex key code with a one-cycle valid strobe. It sits directly upstream of the keypad encoder/register-write path: `key_code`/`key_valid` feed the register bank write data and enable, and `scan_col` replaces the free-running 2-bit column counter.

## Interface
- `SCAN_DIV`, default 16'd1000: clock cycles each column is driven; one "tick" per dwell; must be ≥ 4.
- `DEB_COUNT`, default 4'd4: consecutive consistent ticks required to accept a press or a release; must be ≥ 1.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `row_n` in 4: keypad rows, active-low, asynchronous to `clk`.
- `col_n` out 4: keypad column drive, active-low, exactly one bit low at all times.
- `scan_col` out 2: index of the column currently driven.
- `key_code` out 4: hex code of the last accepted key; held until the next accept.
- `key_valid` out 1: one-cycle pulse when a new key is accepted.
- `key_held` out 1: high from accept until the release is debounced.

## Operation
- `row_n` passes through a 2-FF synchroniser, giving `row_s`. A row is "pressed" when its `row_s` bit is 0.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. `tick` = (`div` == SCAN_DIV-1). All decisions are made on `tick`, at the end of the dwell, so the rows have settled.
- Sample on tick: valid when exactly one row is low (one-hot-low); none when all rows are high; invalid for any other pattern (ghosting or multi-key).
- FSM states: SCAN, DEBOUNCE, HELD.
  - SCAN, tick, valid sample: latch `{row,col}` into `cand`, `deb_cnt`=1, go to DEBOUNCE (if DEB_COUNT==1, accept immediately). Otherwise advance the column (3→0 wrap) and stay in SCAN.
  - DEBOUNCE, tick: if the sample equals `cand`, `deb_cnt`++. When `deb_cnt` reaches DEB_COUNT, accept and go to HELD. On any mismatch (none, invalid, or a different row), go to SCAN and advance the column.
  - HELD, tick: if none, `deb_cnt`++, else `deb_cnt`=0. When `deb_cnt` reaches DEB_COUNT, go to SCAN and advance the column.
- On accept: `key_code`←map(`cand`), `key_valid`=1 for one cycle, `key_held`=1. `key_held` clears on the HELD→SCAN transition.
- The column is frozen in DEBOUNCE and HELD.
- Key map, rows top-to-bottom, cols left-to-right: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D.
- `deb_cnt` is 4 bits and saturates; it never wraps.

## Timing
- Reset values: `col_n`=4'b1110, `scan_col`=0, `key_code`=0, `key_valid`=0, `key_held`=0. Also `div`=0, state SCAN, synchroniser flops all 1.
- A column change on `col_n`/`scan_col` takes effect the cycle after the tick.
- Accept latency: `key_valid` is asserted in the cycle after the DEB_COUNT-th consistent tick. Worst-case press-to-valid ≈ (4+DEB_COUNT)·SCAN_DIV+3 cycles.
- `key_code` and `key_valid` change in the same cycle; `key_code` is stable at least until the next `key_valid`.
- Synchronous reset asserted mid-DEBOUNCE or mid-HELD returns to the reset values on the next edge, with no `key_valid` pulse.
- A held key never re-pulses. A release shorter than DEB_COUNT ticks does not end HELD.

## Structure
- Shared package `keypad_pkg`:
  - `kp_state_t` enum (SCAN, DEBOUNCE, HELD).
  - `KP_ROWS`/`KP_COLS`=4.
  - `kp_map(row,col)` function returning the hex code.
- Sub-module `sync_2ff` (parameterised width, reset to all-ones) for `row_n`.
- Divider, FSM and output registers live in `keypad_scan`.

## Test plan
Bench parameters: SCAN_DIV=4, DEB_COUNT=3.
- Reset then idle rows=4'hF → `col_n` cycles 1110→1101→1011→0111→1110, changing every 4 cycles; `key_valid` stays 0.
- Hold row1 low while col2 is driven → exactly one `key_valid` pulse with `key_code`=4'h6, `key_held`=1, `col_n` frozen at 1011 for the whole hold.
- Row0 low for 2 ticks on col3, then released → no `key_valid`; scanning resumes at col0.
- After accept, rows high 2 ticks, low 1 tick, then high 3 ticks → `key_held` falls only after the final 3-tick run; no second pulse.
- Rows=4'b1100 on any column → treated as invalid; no accept, scanning continues.
- `rst_n`=0 for one cycle mid-DEBOUNCE → all outputs return to reset values; no `key_valid` pulse.
